pipelined_csel_adder: RTL and testbench
=======================================

Name: pipelined_csel_adder

Overview:
- Parametrised, pipelined successor to the 16-bit modified carry-select adder.
- Splits a WIDTH-bit add/subtract into STAGES equal segments. Each segment is resolved in its own pipeline stage by a carry-select cell that precomputes the carry-in=0 and carry-in=1 results, then muxes on the registered carry from the previous stage.
- Adds a valid/ready handshake with backpressure and an add/subtract mode.
- Sits between operand-producing datapath logic and result consumers in the arithmetic unit.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be ≥ 2.
- STAGES, 4, number of pipeline stages, equal to the number of segments. WIDTH % STAGES must be 0; elaboration fails otherwise.
- SEG, WIDTH/STAGES, segment width (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry in (add mode only)
- sub  input  1  0 = a+b+cin; 1 = a-b (cin ignored)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out; in sub mode, 1 = no borrow (a ≥ b unsigned)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All stage valid bits cleared; out_valid=0.
  - sum=0, cout=0 (all stage data registers zeroed).
  - in_ready=1 on the first cycle after reset.
  - Reset mid-operation discards every in-flight result; no partial result is ever presented.
- Operand conditioning at the input:
  - b_eff = sub ? ~b : b
  - c0 = sub ? 1 : cin
- Stage k (0..STAGES-1) computes segment bits [k*SEG +: SEG]:
  - s0 = a_seg + b_seg + 0 and s1 = a_seg + b_seg + 1, each SEG+1 bits wide.
  - Selects s1 if the registered incoming carry is 1, else s0.
  - Stores SEG result bits plus the carry.
  - Unprocessed upper operand bits travel with the token; completed lower result bits travel with the token.
- Stage 0 uses c0 directly from the input.
- Latency: exactly STAGES cycles from an accepted input (in_valid & in_ready at edge N) to out_valid=1 after edge N+STAGES-1, given no stall.
- Throughput: one operation per cycle when out_ready=1.
- Stall rule (global enable):
  - adv = ~out_valid | out_ready
  - in_ready = adv
  - All stage registers load only when adv=1.
  - When adv=0, every stage holds and sum/cout/out_valid are stable.
- Bubbles:
  - Stage valid bits propagate with data; invalid stages still shift when adv=1.
  - Bubbles are not compressed.
- Output handshake:
  - A result is consumed on a clk edge with out_valid & out_ready.
  - sum/cout must not change while out_valid=1 and out_ready=0.
- in_valid=0 while adv=1 inserts a bubble.
- Simultaneous accept and consume in the same cycle is legal; the pipeline advances.
- Wrap-around:
  - The sum is modulo 2^WIDTH.
  - Carry is reported only on cout: FFFF+FFFF → sum FFFE, cout 1.
- STAGES=1 degenerates to a single registered carry-select adder with latency 1.

Optional Feature:
- Macro: PIPELINED_CSEL_OVF_EN
- When defined:
  - Adds output port ovf (1 bit): signed two's-complement overflow of the operation.
  - ovf = (a_msb == b_eff_msb) & (sum_msb != a_msb).
  - a_msb and b_eff_msb are carried down the pipeline alongside the token.
  - ovf resets to 0 and obeys the same hold/stall rules as sum.
- When undefined: no ovf port and no extra flops.

Decomposition:
- Shared package adder_pkg:
  - localparam defaults ADDER_WIDTH_DEF=16 and ADDER_STAGES_DEF=4.
  - Mode encoding constants MODE_ADD=1'b0 and MODE_SUB=1'b1.
- Sub-module csel_segment (combinational):
  - Ports: SEG-bit a, b, carry in → SEG-bit sum, carry out.
  - Contains the dual-adder carry-select mux.
  - Instantiated once per stage via a generate loop.
- Pipeline registers and handshake logic live in the top module.

Test Plan:
- Reset then a=0001, b=0001, cin=0, sub=0, in_valid=1 held one cycle, out_ready=1 → out_valid rises exactly 4 cycles after accept; sum=0002, cout=0.
- Back-to-back stream of (0001..001E doubled) plus FFFF+FFFF, FFEE+FFEE, FEEF+FEEF, F1EF+F1EF → one result per cycle in order; the last four give sum=FFFE/FFDC/FDDE/E3DE with cout=1.
- Subtract: a=0005, b=0007, sub=1 → sum=FFFE, cout=0; a=0007, b=0005 → sum=0002, cout=1.
- Backpressure: 3 ops in flight, out_ready=0 for 5 cycles → in_ready=0, sum/cout/out_valid constant; on release, results emerge in order with none lost or duplicated.
- Reset asserted with 2 ops in flight → out_valid=0 next cycle; no stale result appears after rst_n returns high.
- With WIDTH=32, STAGES=8, macro defined: a=7FFFFFFF, b=00000001, add → sum=80000000, ovf=1, cout=0, latency 8.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared defaults and mode encoding for the pipelined carry-select adder family.
package adder_pkg;
  localparam int ADDER_WIDTH_DEF  = 16;
  localparam int ADDER_STAGES_DEF = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/csel_segment.sv
// One carry-select cell: both carry-in outcomes are precomputed, the incoming carry picks one.
module csel_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);
  logic [SEG:0] s0;
  logic [SEG:0] s1;

  always_comb begin
    s0 = {1'b0, a} + {1'b0, b};
    s1 = {1'b0, a} + {1'b0, b} + (SEG+1)'(1);
    {cout, sum} = cin ? s1 : s0;
  end
endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select add/subtract, one SEG-bit segment per stage, valid/ready with global stall.
// Optional signed-overflow output enabled by defining PIPELINED_CSEL_OVF_EN.
module pipelined_csel_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDER_WIDTH_DEF,
  parameter int STAGES = ADDER_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_CSEL_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int SEG = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_csel_adder: WIDTH must be >= 2 and a multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  always_comb begin
    b_eff = (sub == MODE_SUB) ? ~b : b;
    c0    = (sub == MODE_SUB) ? 1'b1 : cin;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             vld_d, vld_q;
    logic             cy_d, cy_q;
    logic [WIDTH-1:0] opa_d, opa_q;
    logic [WIDTH-1:0] opb_d, opb_q;
    logic [WIDTH-1:0] res_d, res_q;
    logic [WIDTH-1:0] a_in, b_in, r_in;
    logic             c_in, v_in;
    logic [SEG-1:0]   seg_sum;
    logic             seg_cout;

    // Stage 0 reads the conditioned inputs; later stages read the previous stage's token.
    if (k == 0) begin : g_head
      always_comb begin
        a_in = a;
        b_in = b_eff;
        r_in = '0;
        c_in = c0;
        v_in = in_valid;
      end
    end else begin : g_body
      always_comb begin
        a_in = g_stage[k-1].opa_q;
        b_in = g_stage[k-1].opb_q;
        r_in = g_stage[k-1].res_q;
        c_in = g_stage[k-1].cy_q;
        v_in = g_stage[k-1].vld_q;
      end
    end

    csel_segment #(.SEG(SEG)) u_seg (
      .a    (a_in[k*SEG +: SEG]),
      .b    (b_in[k*SEG +: SEG]),
      .cin  (c_in),
      .sum  (seg_sum),
      .cout (seg_cout)
    );

    always_comb begin
      vld_d = v_in;
      opa_d = a_in;
      opb_d = b_in;
      cy_d  = seg_cout;
      res_d = r_in;
      res_d[k*SEG +: SEG] = seg_sum;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        opa_q <= '0;
        opb_q <= '0;
        res_q <= '0;
      end else if (adv) begin
        vld_q <= vld_d;
        cy_q  <= cy_d;
        opa_q <= opa_d;
        opb_q <= opb_d;
        res_q <= res_d;
      end
    end
  end

  // Single global enable: the whole pipe moves unless a held result is waiting at the output.
  assign out_valid = g_stage[STAGES-1].vld_q;
  assign sum       = g_stage[STAGES-1].res_q;
  assign cout      = g_stage[STAGES-1].cy_q;
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

`ifdef PIPELINED_CSEL_OVF_EN
  logic a_msb, b_msb;
  assign a_msb = g_stage[STAGES-1].opa_q[WIDTH-1];
  assign b_msb = g_stage[STAGES-1].opb_q[WIDTH-1];
  assign ovf   = (a_msb == b_msb) & (sum[WIDTH-1] != a_msb);
`endif

  logic unused_last_ops;
  assign unused_last_ops = ^{g_stage[STAGES-1].opa_q, g_stage[STAGES-1].opb_q};
endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Scoreboard bench for pipelined_csel_adder: directed stimulus, queued expectations, decoupled monitor.
module tb_pipelined_csel_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cin, sub, cout;
`ifdef PIPELINED_CSEL_OVF_EN
  logic        ovf;
  logic        ovf2;
`endif

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [31:0] a2, b2, sum2;
  logic        cin2, sub2, cout2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipelined_csel_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
`ifdef PIPELINED_CSEL_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  pipelined_csel_adder #(.WIDTH(32), .STAGES(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .sub(sub2),
    .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2),
`ifdef PIPELINED_CSEL_OVF_EN
    .ovf(ovf2),
`endif
    .cout(cout2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drives one operation; returns once it will be accepted on the coming edge.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                      input logic ts, input logic [15:0] esum, input logic ecout);
    int t;
    exp_t e;
    @(posedge clk); #1;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=in_ready0 required=in_ready1");
    end
    e.sum = esum;
    e.cout = ecout;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result actual=%h required=none", sum);
      end else begin
        e = exp_q.pop_front();
        check("sum", {48'd0, sum}, {48'd0, e.sum});
        check("cout", {63'd0, cout}, {63'd0, e.cout});
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat;
    int seen;
    logic [15:0] hold_sum;
    logic        hold_cout;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum", {48'd0, sum}, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Single op, latency measurement.
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 4);
    idle(2);

    // Back-to-back stream with wrap-around cases at the end.
    for (int i = 1; i <= 30; i++) begin
      send(16'(i), 16'(i), 1'b0, 1'b0, 16'(2 * i), 1'b0);
    end
    send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1);
    send(16'hFFEE, 16'hFFEE, 1'b0, 1'b0, 16'hFFDC, 1'b1);
    send(16'hFEEF, 16'hFEEF, 1'b0, 1'b0, 16'hFDDE, 1'b1);
    send(16'hF1EF, 16'hF1EF, 1'b0, 1'b0, 16'hE3DE, 1'b1);
    send(16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0);
    // Subtract: cin must be ignored.
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    send(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    idle(8);

    // Backpressure with three ops in flight.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
    send(16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    hold_sum = sum;
    hold_cout = cout;
    check("stall_head_sum", {48'd0, sum}, 64'h3333);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      check("stall_out_valid", {63'd0, out_valid}, 64'd1);
      check("stall_sum", {48'd0, sum}, {48'd0, hold_sum});
      check("stall_cout", {63'd0, cout}, {63'd0, hold_cout});
    end
    out_ready = 1'b1;
    idle(8);
    check("stall_drained", exp_q.size(), 0);

    // Reset with two ops in flight.
    send(16'h0101, 16'h0101, 1'b0, 1'b0, 16'h0202, 1'b0);
    send(16'h0303, 16'h0303, 1'b0, 1'b0, 16'h0606, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_sum", {48'd0, sum}, 64'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("no_stale_after_reset", seen, 0);

    // 32-bit, 8-stage instance.
    @(posedge clk); #1;
    a2 = 32'h7FFFFFFF; b2 = 32'h00000001; cin2 = 1'b0; sub2 = 1'b0; in_valid2 = 1'b1;
    check("w32_in_ready", {63'd0, in_ready2}, 64'd1);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    lat = 1;
    while (!out_valid2 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w32_latency", lat, 8);
    check("w32_sum", {32'd0, sum2}, 64'h80000000);
    check("w32_cout", {63'd0, cout2}, 64'd0);
`ifdef PIPELINED_CSEL_OVF_EN
    check("w32_ovf", {63'd0, ovf2}, 64'd1);
    check("w16_ovf_idle", {63'd0, ovf}, 64'd0);
`endif

    lat = 0;
    while (exp_q.size() != 0 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
